// File: rtl/jpeg_pkg.sv
// Shared JPEG byte-stream constants, the FIFO word layout and a byte-lane selector.
// Used by the tail serializer and its word FIFO.
// Stored words keep the marker mask above the data, so each entry is {nostuff, data}.
package jpeg_pkg;

  localparam logic [7:0] JPEG_MARKER_BYTE = 8'hFF;
  localparam logic [7:0] JPEG_STUFF_BYTE  = 8'h00;

  typedef struct packed {
    logic [31:0] nostuff;
    logic [31:0] data;
  } fifo_word_t;

  // Lane 0 is the most significant byte, because it leaves the serializer first.
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Word FIFO holding {nostuff, data} pairs between the bit packer and the byte serializer.
// Latency: a word written at one edge can be read from dout after that edge (registered pointers).
// Backpressure: none upstream; a push while full is dropped and flagged in simulation.
module word_fifo
  import jpeg_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fifo_word_t din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output fifo_word_t dout
);

  localparam int AW = $clog2(DEPTH);

  fifo_word_t  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_push_ok;
  logic        w_pop_ok;

  // The extra pointer bit tells a full FIFO from an empty one when the indices match.
  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign dout      = r_mem[r_rptr[AW-1:0]];

  // Storage write; the contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr[AW-1:0]] <= din;
    end
  end

  // Pointer update; a simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // The upstream must never push into a full FIFO; such a word is lost.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full))
    else $error("word_fifo: enqueue while full, word dropped");

endmodule

// File: rtl/insert_stuff.sv
// Byte serializer with JPEG 0xFF/0x00 stuffing; emits 32-bit words MSB byte first.
// Latency: 2 cycles from enqueue to the first valid byte when idle; 1 byte/cycle sustained.
// Backpressure: none; the word FIFO absorbs bursts, and an enqueue while full is dropped.
module insert_stuff
  import jpeg_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enqueue,
  input  logic [31:0] wdata,
  input  logic [31:0] wdata_nostuff,
  output logic        valid,
  output logic [7:0]  rdata
);

  fifo_word_t w_din;
  fifo_word_t w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic [7:0] w_cur_byte;
  logic [7:0] w_cur_mask;
  logic       w_set_stuff;

  fifo_word_t r_word;
  logic [1:0] r_idx;
  logic       r_have;
  logic       r_stuff;
  logic       r_valid;
  logic [7:0] r_rdata;

  assign w_din = '{nostuff: wdata_nostuff, data: wdata};

  word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enqueue),
    .din   (w_din),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .dout  (w_head)
  );

  assign w_cur_byte  = lane_byte(r_word.data, r_idx);
  assign w_cur_mask  = lane_byte(r_word.nostuff, r_idx);
  // An unflagged 0xFF data byte needs a 0x00 stuff byte after it; a flagged one is a marker.
  assign w_set_stuff = r_have && !r_stuff &&
                       (w_cur_byte == JPEG_MARKER_BYTE) && (w_cur_mask == 8'h00);
  // Refill when idle, or while the last byte goes out without creating a stuff byte.
  // A stuff byte for the last lane is emitted first, and the refill overlaps it.
  assign w_pop = !w_empty &&
                 (!r_have || (!r_stuff && (r_idx == 2'd3) && !w_set_stuff));

  // Serializer: stuff byte first, then the current data byte, then an optional refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word  <= '0;
      r_idx   <= 2'd0;
      r_have  <= 1'b0;
      r_stuff <= 1'b0;
      r_valid <= 1'b0;
      r_rdata <= JPEG_STUFF_BYTE;
    end else begin
      if (r_stuff) begin
        r_valid <= 1'b1;
        r_rdata <= JPEG_STUFF_BYTE;
        r_stuff <= 1'b0;
      end else if (r_have) begin
        r_valid <= 1'b1;
        r_rdata <= w_cur_byte;
        r_stuff <= w_set_stuff;
        r_idx   <= r_idx + 2'd1;
        if (r_idx == 2'd3) r_have <= 1'b0;
      end else begin
        // rdata keeps the last emitted byte while idle
        r_valid <= 1'b0;
      end
      // The refill has the final say over the index and word state.
      if (w_pop) begin
        r_word <= w_head;
        r_idx  <= 2'd0;
        r_have <= 1'b1;
      end
    end
  end

  assign valid = r_valid;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_insert_stuff.sv
// Self-checking bench for insert_stuff: directed cases and a randomized stream.
// The reference model expands each word into its expected bytes.
// Outputs are sampled on the falling clock edge.
module tb_insert_stuff;

  logic        clk;
  logic        rst;
  logic        enqueue;
  logic [31:0] wdata;
  logic [31:0] wdata_nostuff;
  logic        valid;
  logic [7:0]  rdata;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: expected output bytes, in order, for all words enqueued while the monitor is on
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  bit         mon_on = 1'b0;
  int         cyc = 0;
  int         n_vld = 0;
  int         first_vld = -1;
  int         last_vld = -1;
  int         unexp = 0;

  insert_stuff #(.DEPTH(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .enqueue       (enqueue),
    .wdata         (wdata),
    .wdata_nostuff (wdata_nostuff),
    .valid         (valid),
    .rdata         (rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Each byte goes out as-is, followed by a zero byte if it is 0xFF and its lane is not flagged.
  function automatic void model_push(input logic [31:0] d, input logic [31:0] m);
    for (int l = 3; l >= 0; l--) begin
      logic [7:0] b;
      logic [7:0] mm;
      b  = d[8*l +: 8];
      mm = m[8*l +: 8];
      exp_q.push_back(b);
      if (b == 8'hFF && mm == 8'h00) exp_q.push_back(8'h00);
    end
  endfunction

  // Stream monitor, active only in the scoreboarded phases
  always @(negedge clk) begin
    if (mon_on && valid === 1'b1) begin
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
      n_vld++;
      if (exp_q.size() == 0) begin
        unexp++;
      end else begin
        mon_e = exp_q.pop_front();
        chk("stream_byte", 32'(rdata), 32'(mon_e));
      end
    end
  end

  // Called right after a falling edge; the word is sampled at the next rising edge.
  task automatic enq(input logic [31:0] d, input logic [31:0] m);
    enqueue       = 1'b1;
    wdata         = d;
    wdata_nostuff = m;
    if (mon_on) model_push(d, m);
    @(negedge clk);
    enqueue = 1'b0;
  endtask

  // Checks n contiguous bytes (first byte in the top used byte of v), then idle with rdata held.
  task automatic expect_stream(input string tag, input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_vld"}, 32'(valid), 32'd1);
      chk({tag, "_dat"}, 32'(rdata), 32'(v[8*(n-1-i) +: 8]));
      @(negedge clk);
    end
    chk({tag, "_idle"}, 32'(valid), 32'd0);
    chk({tag, "_hold"}, 32'(rdata), 32'(v[7:0]));
  endtask

  // Single word from idle: two empty cycles, then the stream.
  task automatic lat_stream(input string tag, input logic [31:0] d, input logic [31:0] m,
                            input logic [127:0] v, input int n);
    enq(d, m);
    chk({tag, "_lat0"}, 32'(valid), 32'd0);
    @(negedge clk);
    chk({tag, "_lat1"}, 32'(valid), 32'd0);
    @(negedge clk);
    expect_stream(tag, v, n);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_unexpected"}, 32'(unexp), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] m;
    rst = 1'b0; enqueue = 1'b0; wdata = '0; wdata_nostuff = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_vld", 32'(valid), 32'd0);
    chk("rst_dat", 32'(rdata), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_vld", 32'(valid), 32'd0);

    // Plain word
    lat_stream("t1", 32'h12345678, 32'h0, 128'h12345678, 4);
    // Stuffing
    lat_stream("t2", 32'hFF00FFAB, 32'h0, 128'hFF0000FF00AB, 6);
    // Marker passthrough, full and partial masks
    lat_stream("t3a", 32'hFFD8FFE0, 32'hFFFFFFFF, 128'hFFD8FFE0, 4);
    lat_stream("t3b", 32'hFFFFFFFF, 32'hFF000000, 128'hFFFF00FF00FF00, 7);

    // Trailing stuff byte ahead of a waiting word
    enq(32'hAABBCCFF, 32'h0);
    enq(32'h01020304, 32'h0);
    @(negedge clk);
    expect_stream("t4", 128'hAABBCCFF0001020304, 9);

    // Burst of 64 all-0xFF words on consecutive cycles
    mon_on = 1'b1; n_vld = 0; first_vld = -1; last_vld = -1; unexp = 0;
    for (int i = 0; i < 64; i++) enq(32'hFFFFFFFF, 32'h0);
    drain("t5");
    chk("t5_bytes", 32'(n_vld), 32'd512);
    chk("t5_span", 32'(last_vld - first_vld + 1), 32'd512);
    mon_on = 1'b0;

    // Asynchronous reset in the middle of a stuffed word
    enq(32'hFF00FFAB, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_b0", 32'(rdata), 32'hFF);
    @(negedge clk);
    chk("t6_b1", 32'(rdata), 32'h00);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_vld", 32'(valid), 32'd0);
    chk("t6_rst_dat", 32'(rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t6_quiet", 32'(valid), 32'd0);
      @(negedge clk);
    end
    lat_stream("t6", 32'h11223344, 32'h0, 128'h11223344, 4);

    // Randomized stream, biased toward 0xFF bytes and flagged lanes
    mon_on = 1'b1; n_vld = 0; first_vld = -1; last_vld = -1; unexp = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 4) == 0 && exp_q.size() <= 200) begin
        for (int l = 0; l < 4; l++) begin
          d[8*l +: 8] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
          m[8*l +: 8] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        end
        enq(d, m);
      end else begin
        @(negedge clk);
      end
    end
    drain("rnd");
    mon_on = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
